// File: rtl/hazard_issue_unit_if.sv
// Decode/execute/memory hazard bus for the superscalar issue unit.
// Lane i occupies bits [i*REGW +: REGW] of every packed specifier bus.
interface hazard_issue_unit_if #(
  parameter int LANES = 2,
  parameter int REGW  = 5
);
  logic [LANES-1:0]      validD;
  logic [LANES*REGW-1:0] rsD;
  logic [LANES*REGW-1:0] rtD;
  logic [LANES*REGW-1:0] writeregD;
  logic [LANES-1:0]      regwriteD;
  logic [LANES-1:0]      branchD;
  logic [LANES-1:0]      hiloD;
  logic [LANES-1:0]      multD;
  logic [LANES*REGW-1:0] writeregE;
  logic [LANES-1:0]      regwriteE;
  logic [LANES-1:0]      memtoregE;
  logic [LANES*REGW-1:0] writeregM;
  logic [LANES-1:0]      memtoregM;
  logic                  start_multE;
  logic                  stallF;
  logic                  stallD;
  logic [LANES-1:0]      flushE;
  logic [31:0]           stall_count;

  modport master (
    output validD, rsD, rtD, writeregD, regwriteD, branchD, hiloD, multD,
    output writeregE, regwriteE, memtoregE, writeregM, memtoregM, start_multE,
    input  stallF, stallD, flushE, stall_count
  );

  modport slave (
    input  validD, rsD, rtD, writeregD, regwriteD, branchD, hiloD, multD,
    input  writeregE, regwriteE, memtoregE, writeregM, memtoregM, start_multE,
    output stallF, stallD, flushE, stall_count
  );
endinterface

// File: rtl/hazard_issue_unit.sv
// In-order N-way issue/hazard unit: splits dependent bundles across cycles,
// tracks the multiplier busy window and counts decode stall cycles.
module hazard_issue_unit #(
  parameter int LANES       = 2,
  parameter int REGW        = 5,
  parameter int MULT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  hazard_issue_unit_if.slave bus
);
  localparam int CNTW = $clog2(MULT_CYCLES + 1);
  localparam logic [CNTW-1:0] MULT_LOAD = CNTW'(MULT_CYCLES);

  logic [LANES-1:0] issuedQ;
  logic [CNTW-1:0]  multCnt;
  logic [31:0]      stallCnt;
  logic [LANES-1:0] issue;
  logic             doneAll;
  logic             multBusy;
  logic             stall;

  function automatic logic regMatch(input logic [REGW-1:0] r, input logic [REGW-1:0] w);
    return (r == w) && (w != '0);
  endfunction

  assign multBusy = bus.start_multE | (multCnt != '0);

  // Lanes are resolved in order so a lane only sees producers that actually issue ahead of it.
  always_comb begin : issueLogic
    logic [REGW-1:0] rs, rt, wrE, wrM, wrJ;
    logic            hazard;
    logic            prefixDone;
    issue      = '0;
    prefixDone = 1'b1;
    rs         = '0;
    rt         = '0;
    wrE        = '0;
    wrM        = '0;
    wrJ        = '0;
    hazard     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      rs     = bus.rsD[i*REGW +: REGW];
      rt     = bus.rtD[i*REGW +: REGW];
      hazard = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        wrE = bus.writeregE[k*REGW +: REGW];
        wrM = bus.writeregM[k*REGW +: REGW];
        if (bus.memtoregE[k] && (regMatch(rs, wrE) || regMatch(rt, wrE)))
          hazard = 1'b1;
        if (bus.branchD[i] && bus.regwriteE[k] && (regMatch(rs, wrE) || regMatch(rt, wrE)))
          hazard = 1'b1;
        if (bus.branchD[i] && bus.memtoregM[k] && (regMatch(rs, wrM) || regMatch(rt, wrM)))
          hazard = 1'b1;
      end
      if ((bus.hiloD[i] || bus.multD[i]) && multBusy)
        hazard = 1'b1;
      for (int j = 0; j < i; j++) begin
        wrJ = bus.writeregD[j*REGW +: REGW];
        if (issue[j] && bus.regwriteD[j] && (regMatch(rs, wrJ) || regMatch(rt, wrJ)))
          hazard = 1'b1;
        if (issue[j] && bus.multD[j] && (bus.hiloD[i] || bus.multD[i]))
          hazard = 1'b1;
      end
      issue[i]   = bus.validD[i] & ~issuedQ[i] & ~hazard & prefixDone & ~reset;
      prefixDone = prefixDone & (issuedQ[i] | ~bus.validD[i] | issue[i]);
    end
    doneAll = prefixDone;
  end

  assign stall           = ~doneAll & ~reset;
  assign bus.stallD      = stall;
  assign bus.stallF      = stall;
  assign bus.flushE      = ~issue;
  assign bus.stall_count = stallCnt;

  // Partial-issue mask clears once the whole bundle has gone, so the next bundle starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      issuedQ <= '0;
    end else if (doneAll) begin
      issuedQ <= '0;
    end else begin
      issuedQ <= issuedQ | issue;
    end
  end

  // A new start always reloads the full window, even mid-count.
  always_ff @(posedge clk) begin
    if (reset) begin
      multCnt <= '0;
    end else if (bus.start_multE) begin
      multCnt <= MULT_LOAD;
    end else if (multCnt != '0) begin
      multCnt <= multCnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end
endmodule
